// File: rtl/bht_access_scheduler_pkg.sv
// Shared definitions for the BHT access scheduler.
//   bht_state_e : scheduler FSM states (clear walk / normal operation)
//   tbl_size()  : number of one-bit entries for a given index width
package bht_access_scheduler_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } bht_state_e;

  function automatic int tbl_size(input int addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/bht_update_fifo.sv
// Circular update queue of {addr, taken} entries with push/pop/flush.
// Also reports whether a compare address matches any queued entry or the
// entry being pushed this cycle, returning the value of the youngest match.
// Ports:
//   clk, rst                     clock, async active-high reset
//   i_push, i_push_addr/taken    enqueue an entry (ignored on flush)
//   i_pop                        dequeue the head entry
//   i_flush                      discard all entries
//   i_cmp_addr                   address to search for
//   o_head_addr/taken            oldest entry
//   o_count, o_full, o_empty     occupancy
//   o_hit, o_hit_val             youngest-match result
module bht_update_fifo #(
  parameter int ADDR_W = 4,
  parameter int QDEPTH = 4,
  parameter int CNT_W  = $clog2(QDEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic              i_push_taken,
  input  logic              i_pop,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_cmp_addr,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic              o_head_taken,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_hit,
  output logic              o_hit_val
);

  localparam int PW = $clog2(QDEPTH);

  logic [ADDR_W-1:0] r_addr [QDEPTH];
  logic [QDEPTH-1:0] r_taken;
  logic [PW-1:0]     r_wp, r_rp;
  logic [CNT_W-1:0]  r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wp <= r_wp + 1'b1;
      if (i_pop)  r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
    end
  end

  // Payload needs no reset: occupancy alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_addr[r_wp]  <= i_push_addr;
      r_taken[r_wp] <= i_push_taken;
    end
  end

  // Scan oldest -> youngest so the last match wins; the same-cycle push is
  // younger than anything stored and overrides last.
  always_comb begin
    o_hit     = 1'b0;
    o_hit_val = 1'b0;
    for (int i = 0; i < QDEPTH; i++) begin
      if ((CNT_W'(i) < r_cnt) && (r_addr[r_rp + PW'(i)] == i_cmp_addr)) begin
        o_hit     = 1'b1;
        o_hit_val = r_taken[r_rp + PW'(i)];
      end
    end
    if (i_push && (i_push_addr == i_cmp_addr)) begin
      o_hit     = 1'b1;
      o_hit_val = i_push_taken;
    end
  end

  assign o_head_addr  = r_addr[r_rp];
  assign o_head_taken = r_taken[r_rp];
  assign o_count      = r_cnt;
  assign o_full       = (r_cnt == CNT_W'(QDEPTH));
  assign o_empty      = (r_cnt == '0);

endmodule

// File: rtl/bht_access_scheduler.sv
// Single-port 1-bit BHT access scheduler. One table access per cycle,
// arbitrated between fetch lookups and queued resolve updates, with
// forwarding of queued outcomes and a full-table clear walk after reset
// or on clear_req.
// Ports:
//   clk, rst                      clock, async active-high reset
//   clear_req / busy              start clear walk / walk in progress
//   lk_valid, lk_addr, lk_ready   lookup handshake
//   pred_valid, pred              prediction, one cycle after acceptance
//   up_valid, up_addr, up_taken,
//   up_ready                      update handshake
//   q_count                       queued updates
//   tbl_en/we/addr/wdata, tbl_rdata  RAM interface (1-cycle read latency)
module bht_access_scheduler
  import bht_access_scheduler_pkg::*;
#(
  parameter int ADDR_W = 4,
  parameter int QDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear_req,
  output logic                       busy,
  input  logic                       lk_valid,
  input  logic [ADDR_W-1:0]          lk_addr,
  output logic                       lk_ready,
  output logic                       pred_valid,
  output logic                       pred,
  input  logic                       up_valid,
  input  logic [ADDR_W-1:0]          up_addr,
  input  logic                       up_taken,
  output logic                       up_ready,
  output logic [$clog2(QDEPTH+1)-1:0] q_count,
  output logic                       tbl_en,
  output logic                       tbl_we,
  output logic [ADDR_W-1:0]          tbl_addr,
  output logic                       tbl_wdata,
  input  logic                       tbl_rdata
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int TBL_N = tbl_size(ADDR_W);

  bht_state_e        r_state, w_next;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_pred_valid, r_hit, r_hit_val;

  logic              w_push, w_pop, w_flush, w_lk_acc;
  logic [ADDR_W-1:0] w_head_addr;
  logic              w_head_taken, w_full, w_empty, w_hit, w_hit_val;
  logic [CNT_W-1:0]  w_count;

  bht_update_fifo #(.ADDR_W(ADDR_W), .QDEPTH(QDEPTH), .CNT_W(CNT_W)) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push       (w_push),
    .i_push_addr  (up_addr),
    .i_push_taken (up_taken),
    .i_pop        (w_pop),
    .i_flush      (w_flush),
    .i_cmp_addr   (lk_addr),
    .o_head_addr  (w_head_addr),
    .o_head_taken (w_head_taken),
    .o_count      (w_count),
    .o_full       (w_full),
    .o_empty      (w_empty),
    .o_hit        (w_hit),
    .o_hit_val    (w_hit_val)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_CLEAR;
    else     r_state <= w_next;
  end

  // Pointer wraps to 0 on the last clear write, so it is already 0 for the
  // next walk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     r_clr_ptr <= '0;
    else if (r_state == ST_CLEAR) r_clr_ptr <= r_clr_ptr + 1'b1;
  end

  always_comb begin
    w_next    = r_state;
    busy      = 1'b0;
    lk_ready  = 1'b0;
    up_ready  = 1'b0;
    tbl_en    = 1'b0;
    tbl_we    = 1'b0;
    tbl_addr  = lk_addr;
    tbl_wdata = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_flush   = 1'b0;
    w_lk_acc  = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        busy     = 1'b1;
        tbl_en   = 1'b1;
        tbl_we   = 1'b1;
        tbl_addr = r_clr_ptr;
        if (r_clr_ptr == ADDR_W'(TBL_N - 1)) w_next = ST_RUN;
      end
      default: begin
        lk_ready = !w_full;
        up_ready = !w_full;
        w_lk_acc = lk_valid && !w_full;
        // An update offered alongside clear_req is handshaken but discarded.
        w_push   = up_valid && !w_full && !clear_req;
        if (clear_req) begin
          // Queue is discarded, so no drain; a lookup still gets its read.
          w_next  = ST_CLEAR;
          w_flush = 1'b1;
          if (w_lk_acc) begin
            tbl_en   = 1'b1;
            tbl_addr = lk_addr;
          end
        end else if (w_full || (!lk_valid && !w_empty)) begin
          tbl_en    = 1'b1;
          tbl_we    = 1'b1;
          tbl_addr  = w_head_addr;
          tbl_wdata = w_head_taken;
          w_pop     = 1'b1;
        end else if (lk_valid) begin
          tbl_en   = 1'b1;
          tbl_addr = lk_addr;
        end
      end
    endcase
  end

  // Forwarding result is captured at acceptance, when the queue contents
  // that must override the RAM value are known.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pred_valid <= 1'b0;
      r_hit        <= 1'b0;
      r_hit_val    <= 1'b0;
    end else begin
      r_pred_valid <= w_lk_acc;
      if (w_lk_acc) begin
        r_hit     <= w_hit;
        r_hit_val <= w_hit_val;
      end
    end
  end

  assign pred_valid = r_pred_valid;
  assign pred       = r_pred_valid && (r_hit ? r_hit_val : tbl_rdata);
  assign q_count    = w_count;

endmodule

// File: tb/tb_bht_access_scheduler.sv
module tb_bht_access_scheduler;
  localparam int QD = 4;
  localparam int N  = 16;

  logic       clk = 1'b0, rst = 1'b1, clear_req = 1'b0;
  logic       lk_valid = 1'b0, up_valid = 1'b0, up_taken = 1'b0;
  logic [3:0] lk_addr = '0, up_addr = '0;
  logic       busy, lk_ready, pred_valid, pred, up_ready;
  logic [2:0] q_count;
  logic       tbl_en, tbl_we, tbl_wdata, tbl_rdata;
  logic [3:0] tbl_addr;

  bht_access_scheduler #(.ADDR_W(4), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst), .clear_req(clear_req), .busy(busy),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .pred_valid(pred_valid), .pred(pred),
    .up_valid(up_valid), .up_addr(up_addr), .up_taken(up_taken), .up_ready(up_ready),
    .q_count(q_count), .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM with 1-cycle read latency, plus a poke port.
  logic [N-1:0] mem;
  logic       poke_en = 1'b0, poke_val = 1'b0;
  logic [3:0] poke_addr = '0;
  logic       mon_en = 1'b0;
  int         bad_wr = 0;
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
    if (poke_en) mem[poke_addr] <= poke_val;
    if (mon_en && tbl_en && tbl_we && tbl_wdata) bad_wr <= bad_wr + 1;
  end

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic idle_in();
    lk_valid = 1'b0; up_valid = 1'b0; clear_req = 1'b0;
  endtask

  // Directed vectors, applied from RUN with an empty queue and zeroed table.
  typedef struct {
    logic lv; logic [3:0] la; logic uv; logic [3:0] ua; logic ut;
    logic en; logic we; logic [3:0] a; logic d;
    logic pv; logic pr; logic [2:0] q;
  } vec_t;
  vec_t tv[11];

  function automatic vec_t mk(input logic lv, input logic [3:0] la, input logic uv,
                              input logic [3:0] ua, input logic ut, input logic en,
                              input logic we, input logic [3:0] a, input logic d,
                              input logic pv, input logic pr, input logic [2:0] q);
    vec_t v;
    v.lv = lv; v.la = la; v.uv = uv; v.ua = ua; v.ut = ut;
    v.en = en; v.we = we; v.a = a; v.d = d; v.pv = pv; v.pr = pr; v.q = q;
    return v;
  endfunction

  // Reference model: architectural table = last accepted outcome per index.
  typedef struct packed { logic [3:0] a; logic t; } ent_t;
  ent_t         m_q[$];
  logic [N-1:0] ref_bht;
  int           m_clr;
  logic         m_pv, m_pred;

  task automatic rstep(input logic lv, input logic [3:0] la, input logic uv,
                       input logic [3:0] ua, input logic ut, input logic cr);
    logic be, full, rdy, ee, ew, ed, dr;
    logic [3:0] ea;
    lk_valid = lv; lk_addr = la; up_valid = uv; up_addr = ua; up_taken = ut; clear_req = cr;
    #1;
    be = (m_clr != 0); full = (m_q.size() == QD); rdy = !be && !full;
    chk("r_busy", busy, be);
    chk("r_lk_ready", lk_ready, rdy);
    chk("r_up_ready", up_ready, rdy);
    chk("r_qcount", q_count, m_q.size());
    chk("r_pred_valid", pred_valid, m_pv);
    if (m_pv) chk("r_pred", pred, m_pred);
    ee = 0; ew = 0; ed = 0; dr = 0; ea = '0;
    if (be) begin ee = 1; ew = 1; ea = 4'(N - m_clr); end
    else if (cr) begin if (lv && !full) begin ee = 1; ea = la; end end
    else if (full || (!lv && m_q.size() > 0)) begin
      dr = 1; ee = 1; ew = 1; ea = m_q[0].a; ed = m_q[0].t;
    end else if (lv) begin ee = 1; ea = la; end
    chk("r_tbl_en", tbl_en, ee);
    if (ee) begin
      chk("r_tbl_we", tbl_we, ew);
      chk("r_tbl_addr", tbl_addr, ea);
      if (ew) chk("r_tbl_wdata", tbl_wdata, ed);
    end
    if (uv && rdy && !cr) begin ref_bht[ua] = ut; m_q.push_back('{a: ua, t: ut}); end
    if (dr) void'(m_q.pop_front());
    m_pv = lv && rdy;
    m_pred = ref_bht[la];
    if (cr) begin m_q.delete(); ref_bht = '0; m_clr = N; end
    else if (be) m_clr--;
    cyc();
  endtask

  initial begin
    int nb;
    tv[0]  = mk(1, 3, 1, 7, 1,  1, 0, 3, 0,  0, 0, 0);
    tv[1]  = mk(0, 0, 0, 0, 0,  1, 1, 7, 1,  1, 0, 1);
    tv[2]  = mk(1, 7, 1, 2, 1,  1, 0, 7, 0,  0, 0, 0);
    tv[3]  = mk(1, 2, 1, 2, 0,  1, 0, 2, 0,  1, 1, 1);
    tv[4]  = mk(0, 0, 0, 0, 0,  1, 1, 2, 1,  1, 0, 2);
    tv[5]  = mk(1, 2, 0, 0, 0,  1, 0, 2, 0,  0, 0, 1);
    tv[6]  = mk(0, 0, 0, 0, 0,  1, 1, 2, 0,  1, 0, 1);
    tv[7]  = mk(1, 2, 0, 0, 0,  1, 0, 2, 0,  0, 0, 0);
    tv[8]  = mk(1, 7, 0, 0, 0,  1, 0, 7, 0,  1, 0, 0);
    tv[9]  = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  1, 1, 0);
    tv[10] = mk(0, 0, 0, 0, 0,  0, 0, 0, 0,  0, 0, 0);

    // 1: reset state and clear walk
    cyc(); #1;
    chk("rst_busy", busy, 1);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_qcount", q_count, 0);
    chk("rst_lk_ready", lk_ready, 0);
    cyc();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      #1;
      chk("clr_busy", busy, 1);
      chk("clr_en_we", {tbl_en, tbl_we}, 2'b11);
      chk("clr_addr", tbl_addr, k);
      chk("clr_wdata", tbl_wdata, 0);
      chk("clr_ready", {lk_ready, up_ready}, 2'b00);
      cyc();
    end
    #1;
    chk("run_busy", busy, 0);
    chk("run_lk_ready", lk_ready, 1);
    cyc();

    // directed table
    for (int i = 0; i < 11; i++) begin
      lk_valid = tv[i].lv; lk_addr = tv[i].la;
      up_valid = tv[i].uv; up_addr = tv[i].ua; up_taken = tv[i].ut;
      #1;
      chk($sformatf("tv%0d_en", i), tbl_en, tv[i].en);
      if (tv[i].en) begin
        chk($sformatf("tv%0d_we", i), tbl_we, tv[i].we);
        chk($sformatf("tv%0d_addr", i), tbl_addr, tv[i].a);
        if (tv[i].we) chk($sformatf("tv%0d_wdata", i), tbl_wdata, tv[i].d);
      end
      chk($sformatf("tv%0d_pv", i), pred_valid, tv[i].pv);
      if (tv[i].pv) chk($sformatf("tv%0d_pred", i), pred, tv[i].pr);
      chk($sformatf("tv%0d_q", i), q_count, tv[i].q);
      cyc();
    end
    idle_in();

    // 2: lookup reads RAM
    poke_en = 1'b1; poke_addr = 4'd3; poke_val = 1'b1;
    cyc();
    poke_en = 1'b0; lk_valid = 1'b1; lk_addr = 4'd3;
    #1;
    chk("t2_read", {tbl_en, tbl_we, tbl_addr}, {2'b10, 4'd3});
    cyc();
    lk_valid = 1'b0;
    #1;
    chk("t2_pv", pred_valid, 1);
    chk("t2_pred", pred, 1);
    cyc(); #1;
    chk("t2_pv_drop", pred_valid, 0);
    cyc();

    // 3: same-cycle update forwarded
    up_valid = 1'b1; up_addr = 4'd5; up_taken = 1'b1; lk_valid = 1'b1; lk_addr = 4'd5;
    #1;
    chk("t3_read", {tbl_en, tbl_we, tbl_addr}, {2'b10, 4'd5});
    cyc();
    idle_in();
    #1;
    chk("t3_pred", {pred_valid, pred}, 2'b11);
    chk("t3_drain", {tbl_en, tbl_we, tbl_addr, tbl_wdata}, {2'b11, 4'd5, 1'b1});
    cyc(); #1;
    chk("t3_mem5", mem[5], 1);
    chk("t3_q", q_count, 0);
    cyc();

    // 4: fill queue behind continuous lookups
    lk_valid = 1'b1; lk_addr = 4'd0;
    for (int k = 0; k < 4; k++) begin
      up_valid = 1'b1; up_addr = 4'(8 + k); up_taken = 1'b1;
      #1;
      chk("t4_up_ready", up_ready, 1);
      cyc();
    end
    up_valid = 1'b0;
    #1;
    chk("t4_full_q", q_count, 4);
    chk("t4_full_ready", {up_ready, lk_ready}, 2'b00);
    chk("t4_drain", {tbl_en, tbl_we, tbl_addr, tbl_wdata}, {2'b11, 4'd8, 1'b1});
    cyc(); #1;
    chk("t4_q3", q_count, 3);
    chk("t4_lk_ready", lk_ready, 1);
    idle_in();
    nb = 0;
    while (q_count != 0 && nb < 10) begin nb++; cyc(); end
    chk("t4_drained", q_count, 0);

    // 5: clear_req flushes queue
    lk_valid = 1'b1; lk_addr = 4'd0;
    for (int k = 0; k < 3; k++) begin
      up_valid = 1'b1; up_addr = 4'(12 + k); up_taken = 1'b1;
      cyc();
    end
    idle_in();
    clear_req = 1'b1; mon_en = 1'b1;
    #1;
    chk("t5_q3", q_count, 3);
    chk("t5_no_write", tbl_en && tbl_we, 0);
    cyc();
    clear_req = 1'b0;
    #1;
    chk("t5_q0", q_count, 0);
    nb = 0;
    while (busy && nb < 40) begin nb++; cyc(); end
    chk("t5_busy_cycles", nb, 16);
    mon_en = 1'b0;
    chk("t5_bad_writes", bad_wr, 0);
    chk("t5_mem12", mem[12], 0);

    // 6: lookup in clear_req cycle, then reset mid-walk
    lk_valid = 1'b1; lk_addr = 4'd5; clear_req = 1'b1;
    #1;
    chk("t6_lk_acc", {lk_ready, tbl_en, tbl_we, tbl_addr}, {3'b110, 4'd5});
    cyc();
    idle_in();
    #1;
    chk("t6_pv", {pred_valid, pred}, 2'b10);
    chk("t6_busy", {busy, tbl_addr}, {1'b1, 4'd0});
    for (int k = 0; k < 9; k++) cyc();
    chk("t6_ptr9", tbl_addr, 9);
    rst = 1'b1;
    #1;
    chk("t6_rst", {busy, pred_valid, q_count}, {2'b10, 3'd0});
    cyc();
    rst = 1'b0;
    #1;
    chk("t6_restart", {busy, tbl_addr}, {1'b1, 4'd0});
    for (int k = 0; k < 16; k++) cyc();
    chk("t6_done", busy, 0);

    // 6b: reset suppresses in-flight prediction
    lk_valid = 1'b1; lk_addr = 4'd1; up_valid = 1'b1; up_addr = 4'd1; up_taken = 1'b1;
    cyc();
    idle_in();
    #1;
    chk("t6b_pv", pred_valid, 1);
    rst = 1'b1;
    #1;
    chk("t6b_rst", {pred_valid, q_count, busy}, {1'b0, 3'd0, 1'b1});
    cyc();
    rst = 1'b0;

    // randomized run against reference model
    m_q.delete(); ref_bht = '0; m_clr = N; m_pv = 1'b0; m_pred = 1'b0;
    for (int i = 0; i < 800; i++) begin
      logic cr;
      cr = (m_clr == 0) && ($urandom_range(0, 39) == 0);
      rstep(1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), cr);
    end
    for (int k = 0; k < 60 && (m_clr != 0 || m_q.size() != 0); k++)
      rstep(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
    chk("rand_settled", (m_clr == 0) && (m_q.size() == 0), 1);
    for (int i = 0; i < N; i++) chk($sformatf("rand_mem%0d", i), mem[i], ref_bht[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
